// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: loadable instruction memory, program counter and a
// registered 16-bit Instruction stream with jump, branch-flush, stall and halt.
module instr_fetch_unit #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic [15:0]   Instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          halted
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state;
  logic [15:0] mem [0:(2**AW)-1];
  logic [15:0] w;

  assign w = mem[pc];

  // Memory has no reset so its contents survive a reset; writes only in IDLE.
  always_ff @(posedge clk) begin
    if (reset && state == IDLE && load_en)
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      Instruction <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !load_en) begin
            state <= RUN;
            pc    <= '0;
          end
        end
        RUN: begin
          // Branch redirect outranks stall, jump and halt decode.
          if (branch_taken) begin
            pc          <= branch_target;
            Instruction <= '0;
            instr_valid <= 1'b0;
          end else if (!stall) begin
            if (w == 16'hFFFF) begin
              Instruction <= '0;
              instr_valid <= 1'b0;
              halted      <= 1'b1;
              state       <= HALT;
            end else if (w[15:12] == 4'hC) begin
              Instruction <= w;
              instr_valid <= 1'b1;
              pc          <= w[AW-1:0];
            end else begin
              Instruction <= w;
              instr_valid <= 1'b1;
              pc          <= pc + AW'(1);
            end
          end
        end
        HALT: begin
          if (start) begin
            state  <= RUN;
            pc     <= '0;
            halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the lab datapath.
- Holds a loadable instruction memory and a program counter.
- Presents one registered 16-bit Instruction per cycle to the datapath's Instruction input.
- Handles sequential fetch, absolute jumps, datapath-resolved branch redirects, stalls and halt.

Parameters:
- AW, 8, PC/address width; memory depth is 2**AW words of 16 bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- load_en  input  1  write enable for instruction memory; honoured only in IDLE.
- load_addr  input  AW  memory write address.
- load_data  input  16  memory write data.
- start  input  1  one-cycle pulse that begins execution from PC=0.
- stall  input  1  datapath back-pressure; freezes fetch.
- branch_taken  input  1  datapath-resolved taken branch.
- branch_target  input  AW  redirect address, valid with branch_taken.
- Instruction  output  16  registered instruction to the datapath.
- instr_valid  output  1  Instruction holds a real fetched word.
- pc  output  AW  current program counter.
- halted  output  1  high while in HALT.

Behaviour:
- Reset: reset is sampled low at a posedge.
  - pc=0, Instruction=16'h0000, instr_valid=0, halted=0, state=IDLE.
  - Memory contents are preserved across reset.
  - Reset overrides every other input, including in the middle of a run.
- States: IDLE, RUN, HALT.
- IDLE:
  - load_en=1 writes mem[load_addr]=load_data at the posedge.
  - start=1 with load_en=0 moves to RUN with pc=0. If start and load_en are both high, the write happens and start is ignored.
  - Outputs hold at their reset values.
- RUN, when branch_taken=0 and stall=0, with w=mem[pc] (read combinationally, registered at the posedge):
  - w==16'hFFFF (halt word): Instruction<=16'h0000, instr_valid<=0, halted<=1, pc holds, go to HALT.
  - w[15:12]==4'hC (jump): Instruction<=w, instr_valid<=1, pc<=w[AW-1:0].
  - Otherwise: Instruction<=w, instr_valid<=1, pc<=pc+1 modulo 2**AW, so 2**AW-1 wraps to 0.
- Fetch latency: the word at address A appears on Instruction exactly 1 cycle after pc==A is sampled.
- RUN, stall=1 and branch_taken=0: pc, Instruction and instr_valid all hold.
- RUN, branch_taken=1 (takes priority over stall, jump and halt decode):
  - pc<=branch_target.
  - Instruction<=16'h0000 and instr_valid<=0, which flushes the wrong-path fetch.
  - The next fetch reads mem[branch_target].
- HALT:
  - Outputs hold (instr_valid=0, halted=1).
  - start=1 returns to RUN with pc=0 and halted<=0.
  - branch_taken and stall are ignored.
- load_en is ignored in RUN and HALT; memory is never modified outside IDLE.
- start is ignored in RUN.

Test Plan:
- Reset and load:
  - Stimulus: hold reset=0 for 2 cycles, then reset=1; in IDLE load mem[0..3]=16'h1123, 16'h2456, 16'h3789, 16'hFFFF; pulse start.
  - Response: Instruction shows 1123, 2456, 3789 on consecutive cycles with instr_valid=1; the next cycle gives instr_valid=0, halted=1, pc=3.
- Jump:
  - Stimulus: mem[0]=16'hC005, mem[5]=16'h4111.
  - Response: cycle 1 Instruction=C005 and pc=5; cycle 2 Instruction=4111 and pc=6.
- Stall:
  - Stimulus: assert stall for 3 cycles while Instruction=2456 and pc=2.
  - Response: all outputs frozen for 3 cycles; after release, 3789 follows on the next cycle.
- Branch flush:
  - Stimulus: branch_taken=1, branch_target=8'h10, together with stall=1.
  - Response: next cycle instr_valid=0 and pc=16; the following cycle Instruction=mem[16].
- Wrap:
  - Stimulus: branch to 8'hFF with mem[255]=16'h1000 and mem[0]=16'h2000.
  - Response: Instruction=1000 then 2000; pc sequence is 255, 0, 1.
- Mid-run reset and restart:
  - Stimulus: reset=0 during RUN, then load_en=1 with start=1 in the same IDLE cycle, then a later start after HALT.
  - Response: the reset gives reset values with memory intact; the simultaneous start is ignored but the write lands; start from HALT restarts fetch at pc=0.
